// File: rtl/tnn_pkg.sv
// Shared definitions for the ternary-neuron popcount sequencer:
// popcount port widths, ternary output codes, FSM states and sizing helpers.
package tnn_pkg;

   localparam int PC_IN_W  = 25;
   localparam int PC_OUT_W = 5;
   // Largest value an approximate popcount25 may report (all ones on 5 bits).
   localparam int PC_MAX   = 31;

   localparam logic [1:0] TERN_POS  = 2'b01;
   localparam logic [1:0] TERN_ZERO = 2'b00;
   localparam logic [1:0] TERN_NEG  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_POS,
      ST_NEG,
      ST_DECIDE,
      ST_DONE
   } tnn_state_e;

   function automatic int num_chunks(input int in_bits);
      return (in_bits + PC_IN_W - 1) / PC_IN_W;
   endfunction

   // Wide enough that PC_MAX per chunk over every chunk can never wrap.
   function automatic int acc_width(input int in_bits);
      return $clog2(PC_MAX * num_chunks(in_bits) + 1);
   endfunction

endpackage

// File: rtl/tnn_popcount_sequencer_if.sv
// Job request / result bundle between a neuron client and the sequencer.
interface tnn_popcount_sequencer_if
   import tnn_pkg::*;
#(
   parameter int IN_BITS = 100,
   parameter int ACC_W   = acc_width(IN_BITS)
);

   logic               in_valid;
   logic               in_ready;
   logic [IN_BITS-1:0] pos_vec;
   logic [IN_BITS-1:0] neg_vec;
   logic [ACC_W-1:0]   thr_pos;
   logic [ACC_W-1:0]   thr_neg;
   logic               out_valid;
   logic               out_ready;
   logic [1:0]         out_tern;
   logic [ACC_W-1:0]   pos_sum;
   logic [ACC_W-1:0]   neg_sum;

   modport master (
      output in_valid, pos_vec, neg_vec, thr_pos, thr_neg, out_ready,
      input  in_ready, out_valid, out_tern, pos_sum, neg_sum
   );

   modport slave (
      input  in_valid, pos_vec, neg_vec, thr_pos, thr_neg, out_ready,
      output in_ready, out_valid, out_tern, pos_sum, neg_sum
   );

endinterface

// File: rtl/tnn_chunk_select.sv
// Picks 25-bit chunk k of a vector; bits beyond the vector width read as 0.
module tnn_chunk_select
   import tnn_pkg::*;
#(
   parameter int IN_BITS    = 100,
   parameter int NUM_CHUNKS = num_chunks(IN_BITS),
   parameter int K_W        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
   input  logic [IN_BITS-1:0] vec,
   input  logic [K_W-1:0]     k,
   output logic [PC_IN_W-1:0] operand
);

   logic [NUM_CHUNKS*PC_IN_W-1:0] padded;

   // Zero-pad the vector to a whole number of chunks, then mux out chunk k.
   always_comb begin
      padded               = '0;
      padded[IN_BITS-1:0]  = vec;
      operand              = '0;
      for (int i = 0; i < NUM_CHUNKS; i++) begin
         if (k == K_W'(i)) operand = padded[i*PC_IN_W +: PC_IN_W];
      end
   end

endmodule

// File: rtl/tnn_popcount_sequencer.sv
// Evaluates one ternary neuron by streaming the +1 and -1 activation vectors
// through an external popcount25 unit, one chunk per cycle, then thresholding
// the count difference into {+1, 0, -1}.
module tnn_popcount_sequencer
   import tnn_pkg::*;
#(
   parameter int IN_BITS = 100
) (
   input  logic                clk,
   input  logic                rst,
   tnn_popcount_sequencer_if.slave bus,
   output logic [PC_IN_W-1:0]  pc_operand,
   input  logic [PC_OUT_W-1:0] pc_result,
   output logic                busy
);

   localparam int NUM_CHUNKS = num_chunks(IN_BITS);
   localparam int ACC_W      = acc_width(IN_BITS);
   localparam int K_W        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

   tnn_state_e         state;
   logic [K_W-1:0]     k;
   logic [IN_BITS-1:0] pos_q;
   logic [IN_BITS-1:0] neg_q;
   logic [ACC_W-1:0]   thr_pos_q;
   logic [ACC_W-1:0]   thr_neg_q;
   logic [ACC_W-1:0]   pos_acc;
   logic [ACC_W-1:0]   neg_acc;
   logic [1:0]         tern_q;
   logic [IN_BITS-1:0] sel_vec;
   logic [PC_IN_W-1:0] chunk_op;
   logic               last_chunk;

   // +1 wins over -1 so a zero threshold with zero difference reports +1.
   function automatic logic [1:0] tern_decide(input logic [ACC_W-1:0] p,
                                              input logic [ACC_W-1:0] n,
                                              input logic [ACC_W-1:0] tp,
                                              input logic [ACC_W-1:0] tn);
      logic signed [ACC_W:0] diff;
      logic signed [ACC_W:0] hi;
      logic signed [ACC_W:0] lo;
      diff = $signed({1'b0, p}) - $signed({1'b0, n});
      hi   = $signed({1'b0, tp});
      lo   = -$signed({1'b0, tn});
      if (diff >= hi)      return TERN_POS;
      else if (diff <= lo) return TERN_NEG;
      else                 return TERN_ZERO;
   endfunction

   assign last_chunk = (k == K_W'(NUM_CHUNKS - 1));
   assign sel_vec    = (state == ST_NEG) ? neg_q : pos_q;

   tnn_chunk_select #(
      .IN_BITS    (IN_BITS),
      .NUM_CHUNKS (NUM_CHUNKS),
      .K_W        (K_W)
   ) u_chunk_select (
      .vec     (sel_vec),
      .k       (k),
      .operand (chunk_op)
   );

   // Operand is forced quiet outside the accumulate phases.
   assign pc_operand    = (state == ST_POS || state == ST_NEG) ? chunk_op : '0;

   assign bus.in_ready  = (state == ST_IDLE);
   assign bus.out_valid = (state == ST_DONE);
   assign bus.out_tern  = tern_q;
   assign bus.pos_sum   = pos_acc;
   assign bus.neg_sum   = neg_acc;
   assign busy          = (state != ST_IDLE);

   // Job sequencer: capture, accumulate +1 chunks, accumulate -1 chunks, decide, hand off.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         k       <= '0;
         pos_acc <= '0;
         neg_acc <= '0;
         tern_q  <= TERN_ZERO;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  pos_q     <= bus.pos_vec;
                  neg_q     <= bus.neg_vec;
                  thr_pos_q <= bus.thr_pos;
                  thr_neg_q <= bus.thr_neg;
                  pos_acc   <= '0;
                  neg_acc   <= '0;
                  k         <= '0;
                  state     <= ST_POS;
               end
            end
            ST_POS: begin
               pos_acc <= pos_acc + ACC_W'(pc_result);
               if (last_chunk) begin
                  k     <= '0;
                  state <= ST_NEG;
               end else begin
                  k <= k + K_W'(1);
               end
            end
            ST_NEG: begin
               neg_acc <= neg_acc + ACC_W'(pc_result);
               if (last_chunk) begin
                  k     <= '0;
                  state <= ST_DECIDE;
               end else begin
                  k <= k + K_W'(1);
               end
            end
            ST_DECIDE: begin
               tern_q <= tern_decide(pos_acc, neg_acc, thr_pos_q, thr_neg_q);
               state  <= ST_DONE;
            end
            ST_DONE: begin
               if (bus.out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tnn_popcount_sequencer.sv
// Bench for tnn_popcount_sequencer: a 100-bit instance on an exact popcount
// and a 90-bit instance on a constant-31 popcount stub.
module tb_tnn_popcount_sequencer;
   import tnn_pkg::*;

   localparam int ACC_W   = 7;
   localparam int LAT_EXP = 10;

   logic clk;
   logic rst;

   tnn_popcount_sequencer_if #(.IN_BITS(100), .ACC_W(ACC_W)) bus_a ();
   tnn_popcount_sequencer_if #(.IN_BITS(90),  .ACC_W(ACC_W)) bus_b ();

   logic [24:0] pc_operand_a;
   logic [4:0]  pc_result_a;
   logic        busy_a;
   logic [24:0] pc_operand_b;
   logic [4:0]  pc_result_b;
   logic        busy_b;

   tnn_popcount_sequencer #(.IN_BITS(100)) dut_a (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus_a),
      .pc_operand (pc_operand_a),
      .pc_result  (pc_result_a),
      .busy       (busy_a)
   );

   tnn_popcount_sequencer #(.IN_BITS(90)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus_b),
      .pc_operand (pc_operand_b),
      .pc_result  (pc_result_b),
      .busy       (busy_b)
   );

   always_comb pc_result_a = 5'($countones(pc_operand_a));
   assign pc_result_b = 5'd31;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: ternary decision from plain popcounts of the two vectors.
   function automatic void model(input logic [99:0] p, input logic [99:0] n,
                                 input logic [6:0] tp, input logic [6:0] tn,
                                 output int ps, output int ns, output logic [1:0] t);
      int diff;
      ps   = $countones(p);
      ns   = $countones(n);
      diff = ps - ns;
      if (diff >= int'(tp))       t = 2'b01;
      else if (diff <= -int'(tn)) t = 2'b11;
      else                        t = 2'b00;
   endfunction

   // One job on dut_a; hold > 0 keeps out_ready low that many cycles and pokes in_valid.
   task automatic run_job(input logic [99:0] p, input logic [99:0] n,
                          input logic [6:0] tp, input logic [6:0] tn,
                          input logic [1:0] et, input int eps, input int ens,
                          input int hold, input string nm);
      int lat;
      lat = 0;
      while (bus_a.in_ready !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      bus_a.pos_vec  = p;
      bus_a.neg_vec  = n;
      bus_a.thr_pos  = tp;
      bus_a.thr_neg  = tn;
      bus_a.in_valid = 1'b1;
      @(negedge clk);
      bus_a.in_valid = 1'b0;
      lat = 1;
      while (bus_a.out_valid !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check({nm, " latency"}, 32'(lat), 32'(LAT_EXP));
      check({nm, " tern"}, 32'(bus_a.out_tern), 32'(et));
      check({nm, " pos_sum"}, 32'(bus_a.pos_sum), 32'(eps));
      check({nm, " neg_sum"}, 32'(bus_a.neg_sum), 32'(ens));
      for (int i = 0; i < hold; i++) begin
         bus_a.in_valid = (i == 1);
         @(negedge clk);
         check({nm, " hold out_valid"}, 32'(bus_a.out_valid), 32'd1);
         check({nm, " hold tern"}, 32'(bus_a.out_tern), 32'(et));
         check({nm, " hold in_ready"}, 32'(bus_a.in_ready), 32'd0);
      end
      bus_a.in_valid  = 1'b0;
      bus_a.out_ready = 1'b1;
      @(negedge clk);
      bus_a.out_ready = 1'b0;
      check({nm, " idle in_ready"}, 32'(bus_a.in_ready), 32'd1);
      check({nm, " idle out_valid"}, 32'(bus_a.out_valid), 32'd0);
      check({nm, " idle busy"}, 32'(busy_a), 32'd0);
      check({nm, " pos_sum held"}, 32'(bus_a.pos_sum), 32'(eps));
   endtask

   typedef struct {
      logic [99:0] pos;
      logic [99:0] neg;
      logic [6:0]  tp;
      logic [6:0]  tn;
      logic [1:0]  tern;
      int          ps;
      int          ns;
   } vec_t;

   vec_t tbl[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [99:0] p;
      logic [99:0] n;
      logic [6:0]  tp;
      logic [6:0]  tn;
      logic [1:0]  et;
      int          eps;
      int          ens;
      int          lat;
      bit          spurious;

      tbl[0] = '{{100{1'b1}}, 100'h0, 7'd50, 7'd1, 2'b01, 100, 0};
      tbl[1] = '{100'h0F0F0F0F0F0F0F0F0F0F0F0F0, 100'h0F0F0F0F0F0F0F0F0F0F0F0F0,
                 7'd1, 7'd1, 2'b00, 48, 48};
      tbl[2] = '{100'h3FF, 100'hFFFFFFFFFFFFFFF, 7'd5, 7'd40, 2'b11, 10, 60};
      tbl[3] = '{100'h0, 100'h0, 7'd0, 7'd0, 2'b01, 0, 0};
      tbl[4] = '{100'h0, 100'h1F, 7'd3, 7'd5, 2'b11, 0, 5};
      tbl[5] = '{100'h7F, 100'h3, 7'd5, 7'd9, 2'b01, 7, 2};

      rst = 1'b1;
      bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0;
      bus_a.pos_vec = '0; bus_a.neg_vec = '0; bus_a.thr_pos = '0; bus_a.thr_neg = '0;
      bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0;
      bus_b.pos_vec = '0; bus_b.neg_vec = '0; bus_b.thr_pos = '0; bus_b.thr_neg = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check("reset in_ready", 32'(bus_a.in_ready), 32'd1);
      check("reset out_valid", 32'(bus_a.out_valid), 32'd0);
      check("reset tern", 32'(bus_a.out_tern), 32'd0);
      check("reset pos_sum", 32'(bus_a.pos_sum), 32'd0);
      check("reset neg_sum", 32'(bus_a.neg_sum), 32'd0);
      check("reset pc_operand", 32'(pc_operand_a), 32'd0);
      check("reset busy", 32'(busy_a), 32'd0);
      check("reset b in_ready", 32'(bus_b.in_ready), 32'd1);

      for (int i = 0; i < 6; i++) begin
         run_job(tbl[i].pos, tbl[i].neg, tbl[i].tp, tbl[i].tn,
                 tbl[i].tern, tbl[i].ps, tbl[i].ns, 0, $sformatf("tbl%0d", i));
      end

      // Back-pressure in DONE with an ignored request.
      run_job(tbl[2].pos, tbl[2].neg, tbl[2].tp, tbl[2].tn,
              tbl[2].tern, tbl[2].ps, tbl[2].ns, 5, "hold");
      @(negedge clk);
      check("hold no restart busy", 32'(busy_a), 32'd0);

      // Reset while the third +1 chunk is on the popcount port.
      bus_a.pos_vec = tbl[0].pos; bus_a.neg_vec = tbl[0].neg;
      bus_a.thr_pos = tbl[0].tp;  bus_a.thr_neg = tbl[0].tn;
      bus_a.in_valid = 1'b1;
      @(negedge clk);
      bus_a.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst chunk2 operand", 32'(pc_operand_a), 32'h1FFFFFF);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst in_ready", 32'(bus_a.in_ready), 32'd1);
      check("midrst pc_operand", 32'(pc_operand_a), 32'd0);
      check("midrst out_valid", 32'(bus_a.out_valid), 32'd0);
      check("midrst busy", 32'(busy_a), 32'd0);
      check("midrst pos_sum", 32'(bus_a.pos_sum), 32'd0);
      spurious = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus_a.out_valid !== 1'b0 || busy_a !== 1'b0) spurious = 1'b1;
      end
      check("midrst no output", 32'(spurious), 32'd0);
      run_job(tbl[0].pos, tbl[0].neg, tbl[0].tp, tbl[0].tn,
              tbl[0].tern, tbl[0].ps, tbl[0].ns, 0, "after_rst");

      // Randomized jobs against the reference model.
      for (int r = 0; r < 24; r++) begin
         p = {4'($urandom), $urandom, $urandom, $urandom};
         n = {4'($urandom), $urandom, $urandom, $urandom};
         if (r % 3 == 1) p = p & {4'($urandom), $urandom, $urandom, $urandom};
         if (r % 3 == 2) n = n & {4'($urandom), $urandom, $urandom, $urandom};
         tp = 7'($urandom_range(0, 40));
         tn = 7'($urandom_range(0, 40));
         model(p, n, tp, tn, eps, ens, et);
         run_job(p, n, tp, tn, et, eps, ens, 0, $sformatf("rand%0d", r));
      end

      // 90-bit instance: padded last chunk and worst-case accumulation.
      bus_b.pos_vec = {90{1'b1}};
      bus_b.neg_vec = '0;
      bus_b.thr_pos = 7'd0;
      bus_b.thr_neg = 7'd0;
      bus_b.in_valid = 1'b1;
      @(negedge clk);
      bus_b.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("b chunk3 pad", 32'(pc_operand_b[24:15]), 32'd0);
      check("b chunk3 data", 32'(pc_operand_b[14:0]), 32'h7FFF);
      lat = 4;
      while (bus_b.out_valid !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("b latency", 32'(lat), 32'(LAT_EXP));
      check("b pos_sum", 32'(bus_b.pos_sum), 32'(31 * 4));
      check("b neg_sum", 32'(bus_b.neg_sum), 32'(31 * 4));
      check("b tern", 32'(bus_b.out_tern), 32'd1);
      bus_b.out_ready = 1'b1;
      @(negedge clk);
      bus_b.out_ready = 1'b0;
      check("b idle in_ready", 32'(bus_b.in_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
